rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
- Parametrised multi-port register file. Next generation of the decode-stage register file.
- Adds configurable width, depth and read/write port counts, multi-port write-through bypass with fixed port priority, and a per-register busy scoreboard for hazard detection.
- Sits in Decode: fed by issue logic (reservations) and writeback (writes); drives operand data and busy flags to the stall unit.

Parameters:
- DATA_W, 32, width of each register.
- NUM_REGS, 32, register count; power of two, >=2. Localparam ADDR_W = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, >=1.
- NUM_WR, 2, number of write ports, >=1.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rd_sel  in  NUM_RD x ADDR_W  read addresses.
- rd_data  out  NUM_RD x DATA_W  read data (combinational).
- rd_busy  out  NUM_RD  register read is still pending a write.
- wr_en  in  NUM_WR  write enables.
- wr_sel  in  NUM_WR x ADDR_W  write addresses.
- wr_data  in  NUM_WR x DATA_W  write data.
- rsv_en  in  1  mark rsv_sel as busy (instruction issued).
- rsv_sel  in  ADDR_W  destination being reserved.
- flush  in  1  clear all busy bits.
- busy_cnt  out  $clog2(NUM_REGS+1)  registered count of busy registers.
- wr_conflict  out  1  registered sticky flag: two write ports enabled to the same address in one cycle.

Behaviour:
- Reset (rst high at posedge): all registers <= 0, all busy <= 0, busy_cnt <= 0, wr_conflict <= 0. rst takes priority over every other input.
- Before the first edge with rst high, combinational outputs reflect current state.
- Writes:
  - Commit at posedge for each port with wr_en.
  - On a same-address collision, the highest-indexed port wins, and wr_conflict sets at that edge.
  - wr_conflict stays set until rst.
- Reads:
  - Combinational, zero latency.
  - Bypass: if any enabled write port targets rd_sel[i] this cycle, rd_data[i] = wr_data of the highest-indexed such port; otherwise the stored value.
- Scoreboard, per register r, next-state priority:
  - rst -> 0;
  - else flush -> 0, except rsv_en & rsv_sel==r -> 1 (a same-cycle reservation survives flush);
  - else rsv_en & rsv_sel==r -> 1 (wins over a same-cycle write to r; new producer);
  - else any enabled write to r -> 0;
  - else hold.
- rd_busy[i] = busy[rd_sel[i]] & ~(any enabled write to rd_sel[i] this cycle). Bypass resolves that hazard.
- Reserving an already-busy register keeps it busy; no count change.
- busy_cnt is updated every edge to the popcount of next-state busy. It never exceeds NUM_REGS and does not wrap.
- Writes to a non-busy register are legal; they update data and leave busy at 0.

Optional Feature:
- Macro RF_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 and is never written.
  - Bypass to address 0 is suppressed.
  - busy[0] is never set, so rd_busy is 0 for address 0.
  - Write collisions at address 0 still set wr_conflict.
- Undefined: register 0 behaves as any other register.

Decomposition:
- Package rf_pkg: default constants RF_DATA_W=32, RF_NUM_REGS=32; function to compute ADDR_W; typedef for a write-port struct {en, sel, data}.
- Sub-module rf_scoreboard: busy vector, flush/reserve/clear priority, popcount into busy_cnt, rd_busy generation.
- Data array, bypass and conflict detection stay in rf_mp.

Test Plan:
- Reset, then write port0 r5=0xDEADBEEF; next cycle read r5 on both ports -> 0xDEADBEEF; reset again -> read 0.
- Same cycle: wr_en=2'b11 both to r7, port0=0x1, port1=0x2, read r7 -> rd_data=0x2 (bypass); next cycle stored 0x2, wr_conflict=1 until rst.
- rsv r3 -> busy_cnt=1, rd_busy=1 for r3; cycle with write r3=0x33 -> rd_busy=0, rd_data=0x33; next cycle busy_cnt=0.
- Same cycle: rsv r4 and write r4 -> r4 busy afterwards, busy_cnt=1, data updated.
- Reserve r1, r2, r9, then flush with rsv r10 -> busy_cnt=1, only r10 busy.
- RF_ZERO_REG_EN: write r0=0xFFFF and rsv r0 -> rd_data=0, rd_busy=0, busy_cnt=0; without macro -> 0xFFFF and busy_cnt=1.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, address-width helper and write-port record for rf_mp
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

    // Address width needed to select one of n registers (n >= 2)
    function automatic int rf_addr_w(input int n);
        return $clog2(n);
    endfunction

    localparam int RF_ADDR_W = rf_addr_w(RF_NUM_REGS);

    // One write port at the default geometry
    typedef struct packed {
        logic                 en;
        logic [RF_ADDR_W-1:0] sel;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy scoreboard with busy count and read-side hazard flags
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = rf_addr_w(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    input  logic                     flush,
    input  logic [NUM_REGS-1:0]      wr_hit,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    input  logic [NUM_RD-1:0]        rd_hit,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [CNT_W-1:0]         busy_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Next busy vector: a reservation beats flush and same-cycle writes; writes retire producers
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rsv_en && rsv_sel == ADDR_W'(r)) begin
                busy_nxt[r] = 1'b1;
            end else if (flush || wr_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    // Busy vector and its population count register together
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A pending register is not a hazard when this cycle's write is bypassed to the reader
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy[rd_sel[i*ADDR_W +: ADDR_W]] & ~rd_hit[i];
        end
    end

endmodule

// File: rtl/rf_mp.sv
// rtl/rf_mp.sv - multi-port register file with write-through bypass and busy scoreboard (option: RF_ZERO_REG_EN)
module rf_mp
    import rf_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    localparam int ADDR_W   = rf_addr_w(NUM_REGS),
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_sel,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_sel,
    input  logic                     flush,
    output logic [CNT_W-1:0]         busy_cnt,
    output logic                     wr_conflict
);

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_RD-1:0]   rd_hit;
    logic                conflict_now;

    // Which registers receive any write this cycle (retires their busy bit)
    always_comb begin
        wr_hit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                wr_hit[wr_sel[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // Two enabled ports aiming at the same register, including register 0
    always_comb begin
        conflict_now = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_en[a] && wr_en[b] &&
                    wr_sel[a*ADDR_W +: ADDR_W] == wr_sel[b*ADDR_W +: ADDR_W]) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    // Commit writes in port order so the highest-indexed port lands last; sticky conflict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
            wr_conflict <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !(ZERO_REG && wr_sel[w*ADDR_W +: ADDR_W] == '0)) begin
                    mem[wr_sel[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
            if (conflict_now) begin
                wr_conflict <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] val;
        logic              hit;

        assign sel = rd_sel[i*ADDR_W +: ADDR_W];

        // Stored value, overridden by the highest-indexed write to the same register
        always_comb begin
            val = mem[sel];
            hit = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_sel[w*ADDR_W +: ADDR_W] == sel) begin
                    val = wr_data[w*DATA_W +: DATA_W];
                    hit = 1'b1;
                end
            end
            if (ZERO_REG && sel == '0) begin
                val = '0;
                hit = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = val;
        assign rd_hit[i]                   = hit;
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .flush    (flush),
        .wr_hit   (wr_hit),
        .rd_sel   (rd_sel),
        .rd_hit   (rd_hit),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_rf_mp.sv
// tb/tb_rf_mp.sv - directed vector table plus randomized model comparison for rf_mp
module tb_rf_mp;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  rd_sel;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_sel;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_sel;
    logic        flush;
    logic [5:0]  busy_cnt;
    logic        wr_conflict;

    int n_checks = 0;
    int n_pass   = 0;

    rf_mp #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .NUM_WR   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .rsv_en      (rsv_en),
        .rsv_sel     (rsv_sel),
        .flush       (flush),
        .busy_cnt    (busy_cnt),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [4:0]  ws0;
        logic [31:0] wd0;
        logic [4:0]  ws1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  rsel;
        logic        fl;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        bit          chk;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
        logic        ef;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(logic r, logic [1:0] wen, logic [4:0] ws0, logic [31:0] wd0,
                                 logic [4:0] ws1, logic [31:0] wd1, logic rsv, logic [4:0] rsel,
                                 logic fl, logic [4:0] rs0, logic [4:0] rs1, bit chk,
                                 logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                                 logic [5:0] ec, logic ef);
        vec_t v;
        v.rst = r;  v.wen = wen; v.ws0 = ws0; v.wd0 = wd0; v.ws1 = ws1; v.wd1 = wd1;
        v.rsv = rsv; v.rsel = rsel; v.fl = fl; v.rs0 = rs0; v.rs1 = rs1; v.chk = chk;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model state
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic        m_conf;

    function automatic logic [31:0] exp_rd(input logic [4:0] sel);
        logic [31:0] v;
        if (ZERO && sel == 5'd0) return 32'd0;
        v = m_mem[sel];
        if (wr_en[0] && wr_sel[4:0] == sel) v = wr_data[31:0];
        if (wr_en[1] && wr_sel[9:5] == sel) v = wr_data[63:32];
        return v;
    endfunction

    function automatic logic exp_rb(input logic [4:0] sel);
        logic written;
        written = (wr_en[0] && wr_sel[4:0] == sel) || (wr_en[1] && wr_sel[9:5] == sel);
        return m_busy[sel] && !written;
    endfunction

    task automatic model_update();
        logic [31:0] nb;
        if (rst) begin
            for (int r = 0; r < 32; r++) m_mem[r] = 32'd0;
            m_busy = 32'd0;
            m_conf = 1'b0;
        end else begin
            if (wr_en == 2'b11 && wr_sel[4:0] == wr_sel[9:5]) m_conf = 1'b1;
            nb = flush ? 32'd0 : m_busy;
            if (wr_en[0]) nb[wr_sel[4:0]] = 1'b0;
            if (wr_en[1]) nb[wr_sel[9:5]] = 1'b0;
            if (rsv_en) nb[rsv_sel] = 1'b1;
            if (ZERO) nb[0] = 1'b0;
            m_busy = nb;
            if (wr_en[0] && !(ZERO && wr_sel[4:0] == 5'd0)) m_mem[wr_sel[4:0]] = wr_data[31:0];
            if (wr_en[1] && !(ZERO && wr_sel[9:5] == 5'd0)) m_mem[wr_sel[9:5]] = wr_data[63:32];
        end
    endtask

    initial begin
        logic [31:0] z_ffff;
        logic [1:0]  z_b11;
        logic [1:0]  z_b10;
        logic [5:0]  z_c1;
        z_ffff = ZERO ? 32'd0 : 32'hFFFF;
        z_b11  = ZERO ? 2'b00 : 2'b11;
        z_b10  = ZERO ? 2'b00 : 2'b10;
        z_c1   = ZERO ? 6'd0  : 6'd1;

        rst = 1'b1; rd_sel = '0; wr_en = '0; wr_sel = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;

        //           rst wen  ws0 wd0            ws1 wd1    rsv rsel fl rs0 rs1 chk e0            e1            eb     ec    ef
        vt.push_back(mkv(1, 2'b00, 0, 0,           0, 0,     0, 0,  0, 0,  0,  0, 0,            0,            2'b00, 0,    0));
        vt.push_back(mkv(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,    0, 0,  0, 5,  5,  1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0,    0));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 5,  5,  1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0,    0));
        vt.push_back(mkv(1, 2'b00, 0, 0,           0, 0,     0, 0,  0, 5,  5,  1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0,    0));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 5,  0,  1, 0,            0,            2'b00, 0,    0));
        vt.push_back(mkv(0, 2'b11, 7, 32'h1,       7, 32'h2, 0, 0,  0, 7,  5,  1, 32'h2,        0,            2'b00, 0,    0));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 7,  7,  1, 32'h2,        32'h2,        2'b00, 0,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     1, 3,  0, 3,  7,  1, 0,            32'h2,        2'b00, 0,    1));
        vt.push_back(mkv(0, 2'b01, 3, 32'h33,      0, 0,     0, 0,  0, 3,  3,  1, 32'h33,       32'h33,       2'b00, 1,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 3,  3,  1, 32'h33,       32'h33,       2'b00, 0,    1));
        vt.push_back(mkv(0, 2'b10, 0, 0,           4, 32'h44, 1, 4, 0, 4,  3,  1, 32'h44,       32'h33,       2'b00, 0,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 4,  4,  1, 32'h44,       32'h44,       2'b11, 1,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     1, 1,  0, 1,  4,  1, 0,            32'h44,       2'b10, 1,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     1, 2,  0, 1,  2,  1, 0,            0,            2'b01, 2,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     1, 9,  0, 2,  9,  1, 0,            0,            2'b01, 3,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     1, 10, 1, 9,  10, 1, 0,            0,            2'b01, 4,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 10, 4,  1, 0,            32'h44,       2'b01, 1,    1));
        vt.push_back(mkv(0, 2'b01, 0, 32'hFFFF,    0, 0,     1, 0,  1, 0,  0,  1, z_ffff,       z_ffff,       2'b00, 1,    1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 0,  0,  1, z_ffff,       z_ffff,       z_b11, z_c1, 1));
        vt.push_back(mkv(1, 2'b00, 0, 0,           0, 0,     0, 0,  0, 7,  0,  1, 32'h2,        z_ffff,       z_b10, z_c1, 1));
        vt.push_back(mkv(0, 2'b00, 0, 0,           0, 0,     0, 0,  0, 7,  0,  1, 0,            0,            2'b00, 0,    0));

        foreach (vt[i]) begin
            rst     = vt[i].rst;
            wr_en   = vt[i].wen;
            wr_sel  = {vt[i].ws1, vt[i].ws0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            rsv_en  = vt[i].rsv;
            rsv_sel = vt[i].rsel;
            flush   = vt[i].fl;
            rd_sel  = {vt[i].rs1, vt[i].rs0};
            @(negedge clk);
            if (vt[i].chk) begin
                check($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]), 64'(vt[i].e0));
                check($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(vt[i].e1));
                check($sformatf("v%0d rd_busy", i), 64'(rd_busy), 64'(vt[i].eb));
                check($sformatf("v%0d busy_cnt", i), 64'(busy_cnt), 64'(vt[i].ec));
                check($sformatf("v%0d wr_conflict", i), 64'(wr_conflict), 64'(vt[i].ef));
            end
            @(posedge clk);
            #1;
        end

        for (int c = 0; c < 400; c++) begin
            rst     = (c == 0) || ($urandom_range(0, 63) == 0);
            wr_en   = 2'($urandom_range(0, 3));
            wr_sel  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data = {$urandom, $urandom};
            rsv_en  = ($urandom_range(0, 2) == 0);
            rsv_sel = 5'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 15) == 0);
            rd_sel  = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            @(negedge clk);
            if (c > 0) begin
                check($sformatf("r%0d rd_data0", c), 64'(rd_data[31:0]), 64'(exp_rd(rd_sel[4:0])));
                check($sformatf("r%0d rd_data1", c), 64'(rd_data[63:32]), 64'(exp_rd(rd_sel[9:5])));
                check($sformatf("r%0d rd_busy", c), 64'(rd_busy),
                      64'({exp_rb(rd_sel[9:5]), exp_rb(rd_sel[4:0])}));
                check($sformatf("r%0d busy_cnt", c), 64'(busy_cnt), 64'($countones(m_busy)));
                check($sformatf("r%0d wr_conflict", c), 64'(wr_conflict), 64'(m_conf));
            end
            model_update();
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
